// File: rtl/pattern_stamper_pkg.sv
// pattern_stamper_pkg
//   Shared board/raster constants and types for the pattern stamper slice.
//   Board geometry: BOARD_SIZE x BOARD_SIZE cells, addressed with
//   LOG_BOARD_SIZE bits. Raster counters are HCOUNT_WIDTH/VCOUNT_WIDTH wide.
//   stamper_state_t enumerates the stamper FSM states.
package pattern_stamper_pkg;

    localparam int unsigned BOARD_SIZE     = 64;
    localparam int unsigned LOG_BOARD_SIZE = 6;
    localparam int unsigned HCOUNT_WIDTH   = 11;
    localparam int unsigned VCOUNT_WIDTH   = 10;

    typedef logic [HCOUNT_WIDTH-1:0] hcount_t;
    typedef logic [VCOUNT_WIDTH-1:0] vcount_t;

    // Default pattern edge length in cells (multiple of 8).
    localparam int unsigned PAT_SIZE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READY,
        ARMED,
        STAMP,
        DONE
    } stamper_state_t;

endpackage

// File: rtl/pattern_stamper_buffer.sv
// pattern_buffer
//   PAT_SIZE x PAT_SIZE single-bit cell store for the stamper.
//   Ports:
//     clk_in, rst_in : clock, synchronous active-high clear of all cells
//     wr_en          : write one byte this cycle
//     wr_addr        : byte index k (row k/BYTES_PER_ROW, column group k%BYTES_PER_ROW)
//     wr_data        : byte value; bit 7 lands in the lowest column of the group
//     rd_row, rd_col : cell coordinate for the combinational read
//     rd_bit         : cell value at (rd_row, rd_col)
module pattern_buffer
    import pattern_stamper_pkg::*;
#(
    parameter int unsigned PAT_SIZE = PAT_SIZE_DEFAULT
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  wr_en,
    input  logic [$clog2(PAT_SIZE*PAT_SIZE/8)-1:0] wr_addr,
    input  logic [7:0]                            wr_data,
    input  logic [$clog2(PAT_SIZE)-1:0]           rd_row,
    input  logic [$clog2(PAT_SIZE)-1:0]           rd_col,
    output logic                                  rd_bit
);

    localparam int unsigned CELLS = PAT_SIZE * PAT_SIZE;
    localparam int unsigned CW    = $clog2(CELLS);

    // Row-major flat store: cell (r, c) lives at r*PAT_SIZE + c. Because a row
    // holds exactly BYTES_PER_ROW bytes, byte k starts at cell 8*k.
    logic [CELLS-1:0] cells;
    logic [7:0]       wr_bits;
    logic [CW-1:0]    wr_base;
    logic [CW-1:0]    rd_idx;

    always_comb begin
        wr_bits = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            wr_bits[j] = wr_data[7-j];
        end
        wr_base = CW'({wr_addr, 3'b000});
        rd_idx  = CW'(int'(rd_row) * int'(PAT_SIZE) + int'(rd_col));
        rd_bit  = cells[rd_idx];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cells <= '0;
        end else if (wr_en) begin
            cells[wr_base +: 8] <= wr_bits;
        end
    end

endmodule

// File: rtl/pattern_stamper.sv
// pattern_stamper
//   Loads a PAT_SIZE x PAT_SIZE bitmap over a byte valid/ready stream and, on
//   request, writes it into the life board during one full raster frame at a
//   latched origin. Sits directly upstream of life_logic and delays the raster
//   by one cycle so alive_out/wr_en_out line up with hcount_out/vcount_out.
//   Ports:
//     clk_in, rst_in                 : pixel clock, synchronous active-high reset
//     hcount_in/vcount_in, *sync_in,
//     blank_in                       : raster in
//     byte_in, byte_valid_in,
//     byte_ready_out                 : pattern byte stream
//     origin_x_in, origin_y_in       : stamp origin, latched with stamp_in
//     stamp_in                       : stamp request pulse (honoured in READY)
//     hcount_out .. blank_out        : raster delayed one cycle
//     alive_out, wr_en_out           : cell write stream for life_logic
//     busy_out                       : stamp armed or in progress
//     done_out                       : one-cycle pulse when the frame is stamped
//   Build option: STAMPER_CLEAR_ON_STAMP_EN makes the stamp frame write every
//   on-board cell, clearing everything outside the pattern window.
module pattern_stamper
    import pattern_stamper_pkg::*;
#(
    parameter int unsigned PAT_SIZE = PAT_SIZE_DEFAULT
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [HCOUNT_WIDTH-1:0]   hcount_in,
    input  logic [VCOUNT_WIDTH-1:0]   vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    output logic                      byte_ready_out,
    input  logic [LOG_BOARD_SIZE-1:0] origin_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] origin_y_in,
    input  logic                      stamp_in,
    output logic [HCOUNT_WIDTH-1:0]   hcount_out,
    output logic [VCOUNT_WIDTH-1:0]   vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      blank_out,
    output logic                      alive_out,
    output logic                      wr_en_out,
    output logic                      busy_out,
    output logic                      done_out
);

    localparam int unsigned BYTES_PER_ROW = PAT_SIZE / 8;
    localparam int unsigned NBYTES        = PAT_SIZE * BYTES_PER_ROW;
    localparam int unsigned AW            = $clog2(NBYTES);
    localparam int unsigned CNTW          = $clog2(NBYTES + 1);
    localparam int unsigned IW            = $clog2(PAT_SIZE);
    localparam int unsigned DW            = LOG_BOARD_SIZE + 1;

    stamper_state_t            state, state_next;
    logic [CNTW-1:0]           cnt, cnt_next;
    logic [LOG_BOARD_SIZE-1:0] org_x, org_y;
    logic                      latch_org;
    logic                      accept;
    logic                      buf_we;
    logic [AW-1:0]             buf_addr;

    logic                      frame_start, frame_end;
    logic                      on_board, stamping, in_window;
    logic [DW-1:0]             dx, dy;
    logic                      pat_bit;
    logic                      wr_next, alive_next;

    // ------------------------------------------------------------------
    // Handshake / status
    // ------------------------------------------------------------------
    always_comb begin
        byte_ready_out = !rst_in && (state inside {IDLE, FILL, READY});
        busy_out       = (state == ARMED) || (state == STAMP);
        done_out       = (state == DONE);
        accept         = byte_valid_in && byte_ready_out;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        buf_we     = 1'b0;
        buf_addr   = '0;
        latch_org  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    buf_we     = 1'b1;
                    cnt_next   = CNTW'(1);
                    state_next = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    buf_we   = 1'b1;
                    buf_addr = cnt[AW-1:0];
                    cnt_next = cnt + 1'b1;
                    if (cnt == CNTW'(NBYTES - 1)) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                // A new byte restarts the load and takes priority over stamp_in.
                if (accept) begin
                    buf_we     = 1'b1;
                    cnt_next   = CNTW'(1);
                    state_next = FILL;
                end else if (stamp_in) begin
                    latch_org  = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    state_next = STAMP;
                end
            end
            STAMP: begin
                if (frame_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = READY;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt   <= '0;
            org_x <= '0;
            org_y <= '0;
        end else begin
            cnt <= cnt_next;
            if (latch_org) begin
                org_x <= origin_x_in;
                org_y <= origin_y_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern storage
    // ------------------------------------------------------------------
    pattern_buffer #(
        .PAT_SIZE (PAT_SIZE)
    ) u_buffer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (buf_we),
        .wr_addr (buf_addr),
        .wr_data (byte_in),
        .rd_row  (dy[IW-1:0]),
        .rd_col  (dx[IW-1:0]),
        .rd_bit  (pat_bit)
    );

    // ------------------------------------------------------------------
    // Window arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        frame_start = (hcount_in == '0) && (vcount_in == '0);
        frame_end   = (hcount_in == HCOUNT_WIDTH'(BOARD_SIZE)) &&
                      (vcount_in == VCOUNT_WIDTH'(BOARD_SIZE - 1));
        on_board    = (hcount_in < HCOUNT_WIDTH'(BOARD_SIZE)) &&
                      (vcount_in < VCOUNT_WIDTH'(BOARD_SIZE));
        // ARMED already stamps the (0,0) pixel that triggers the move to STAMP.
        stamping    = (state == STAMP) || ((state == ARMED) && frame_start);

        // One extra bit keeps the sign of the offset visible; low bits are
        // only meaningful while on_board holds.
        dx = {1'b0, hcount_in[LOG_BOARD_SIZE-1:0]} - {1'b0, org_x};
        dy = {1'b0, vcount_in[LOG_BOARD_SIZE-1:0]} - {1'b0, org_y};

        in_window = stamping && on_board &&
                    !dx[DW-1] && (dx < DW'(PAT_SIZE)) &&
                    !dy[DW-1] && (dy < DW'(PAT_SIZE));

`ifdef STAMPER_CLEAR_ON_STAMP_EN
        wr_next = stamping && on_board;
`else
        wr_next = in_window;
`endif
        alive_next = in_window && pat_bit;
    end

    // ------------------------------------------------------------------
    // One-stage raster / write pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            blank_out  <= 1'b0;
            wr_en_out  <= 1'b0;
            alive_out  <= 1'b0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            blank_out  <= blank_in;
            wr_en_out  <= wr_next;
            alive_out  <= alive_next;
        end
    end

endmodule

// File: tb/tb_pattern_stamper.sv
module tb_pattern_stamper;
    import pattern_stamper_pkg::*;

    localparam int P     = PAT_SIZE_DEFAULT;
    localparam int BPR   = P / 8;
    localparam int NB    = P * BPR;
    localparam int B     = BOARD_SIZE;
    localparam int HT    = B + 2;
    localparam int VT    = B + 1;
    localparam int FRAME = HT * VT;
`ifdef STAMPER_CLEAR_ON_STAMP_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic [HCOUNT_WIDTH-1:0]   hcount_in, hcount_out;
    logic [VCOUNT_WIDTH-1:0]   vcount_in, vcount_out;
    logic                      hsync_in, vsync_in, blank_in;
    logic                      hsync_out, vsync_out, blank_out;
    logic [7:0]                byte_in;
    logic                      byte_valid_in, byte_ready_out;
    logic [LOG_BOARD_SIZE-1:0] origin_x_in, origin_y_in;
    logic                      stamp_in;
    logic                      alive_out, wr_en_out, busy_out, done_out;

    pattern_stamper #(.PAT_SIZE(P)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .blank_in       (blank_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .origin_x_in    (origin_x_in),
        .origin_y_in    (origin_y_in),
        .stamp_in       (stamp_in),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .blank_out      (blank_out),
        .alive_out      (alive_out),
        .wr_en_out      (wr_en_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk_in = ~clk_in;

    // Bench bookkeeping
    int n_cmp = 0;
    int n_bad = 0;
    int n_wr, n_alive, n_done;
    bit dut_acc;
    int h_in = 0;
    int v_in = 0;
    logic [7:0] cur_bytes [NB];

    // Reference model: pattern bitmap, load progress and stamp phase
    // (0 = accepting bytes, 1 = waiting for frame start, 2 = sweeping, 3 = finishing)
    bit m_pat [P][P];
    int m_nb     = 0;
    bit m_loaded = 1'b0;
    int m_phase  = 0;
    int m_ox     = 0;
    int m_oy     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, got, exp, h_in, v_in, $time);
        end
    endtask

    task automatic drive_raster();
        hcount_in = HCOUNT_WIDTH'(h_in);
        vcount_in = VCOUNT_WIDTH'(v_in);
        hsync_in  = (h_in == B);
        vsync_in  = (v_in == B);
        blank_in  = (h_in >= B) || (v_in >= B);
    endtask

    function automatic int alive_in_window(input int ox, input int oy);
        int n = 0;
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++)
                if (ox + c < B && oy + r < B && m_pat[r][c]) n++;
        return n;
    endfunction

    function automatic int wr_in_window(input int ox, input int oy);
        int w, h;
        if (CLEAR) return B * B;
        w = (B - ox < P) ? B - ox : P;
        h = (B - oy < P) ? B - oy : P;
        return w * h;
    endfunction

    // One clock: check status outputs for the current inputs, advance the
    // model, then check the registered outputs after the edge.
    task automatic cycle();
        bit m_ready, m_busy, m_done, m_acc, act, onb, inw, e_wr, e_alive;
        int dx, dy, k;
        logic [23:0] e_r;
        #1;
        m_ready = !rst_in && (m_phase == 0);
        m_busy  = (m_phase == 1) || (m_phase == 2);
        m_done  = (m_phase == 3);
        check("ctl", {29'd0, byte_ready_out, busy_out, done_out}, {29'd0, m_ready, m_busy, m_done});
        dut_acc = byte_valid_in && byte_ready_out;
        if (done_out) n_done++;
        m_acc = byte_valid_in && m_ready;

        act = (m_phase == 2) || (m_phase == 1 && h_in == 0 && v_in == 0);
        onb = (h_in < B) && (v_in < B);
        dx  = h_in - m_ox;
        dy  = v_in - m_oy;
        inw = act && onb && dx >= 0 && dx < P && dy >= 0 && dy < P;
        e_wr    = CLEAR ? (act && onb) : inw;
        e_alive = inw ? m_pat[dy][dx] : 1'b0;
        e_r     = {hcount_in, vcount_in, hsync_in, vsync_in, blank_in};

        if (rst_in) begin
            e_wr = 0; e_alive = 0; e_r = '0;
            m_phase = 0; m_nb = 0; m_loaded = 0;
            for (int r = 0; r < P; r++)
                for (int c = 0; c < P; c++) m_pat[r][c] = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (m_acc) begin
                        if (m_loaded) begin
                            m_loaded = 0;
                            m_nb = 0;
                        end
                        k = m_nb;
                        for (int j = 0; j < 8; j++) m_pat[k / BPR][8 * (k % BPR) + j] = byte_in[7 - j];
                        m_nb++;
                        if (m_nb == NB) m_loaded = 1;
                    end else if (stamp_in && m_loaded) begin
                        m_ox = int'(origin_x_in);
                        m_oy = int'(origin_y_in);
                        m_phase = 1;
                    end
                end
                1: if (h_in == 0 && v_in == 0) m_phase = 2;
                2: if (h_in == B && v_in == B - 1) m_phase = 3;
                default: m_phase = 0;
            endcase
        end

        @(posedge clk_in);
        #1;
        check("raster", {8'd0, hcount_out, vcount_out, hsync_out, vsync_out, blank_out}, {8'd0, e_r});
        check("wr", {30'd0, wr_en_out, alive_out}, {30'd0, e_wr, e_alive});
        if (wr_en_out === 1'b1) n_wr++;
        if (alive_out === 1'b1) n_alive++;

        h_in = h_in + 1;
        if (h_in == HT) begin
            h_in = 0;
            v_in = (v_in + 1) % VT;
        end
        drive_raster();
    endtask

    task automatic load_pattern(input int start_k, input bit hold_valid, output int k);
        int g = 0;
        k = start_k;
        while (k < NB && g < 4 * FRAME) begin
            byte_valid_in = hold_valid ? 1'b1 : ($urandom_range(3) != 0);
            byte_in       = cur_bytes[k];
            stamp_in      = !m_loaded && ($urandom_range(7) == 0);
            cycle();
            if (dut_acc) k++;
            g++;
        end
        byte_valid_in = 1'b0;
        stamp_in      = 1'b0;
    endtask

    task automatic wait_pos(input int h, input int v);
        int g = 0;
        while (!(h_in == h && v_in == v) && g < 2 * FRAME) begin
            cycle();
            g++;
        end
    endtask

    task automatic do_stamp(input string tag, input int ox, input int oy,
                            input int at_h, input int at_v,
                            input int exp_wr, input int exp_alive);
        int g = 0;
        byte_valid_in = 1'b0;
        if (at_h >= 0) wait_pos(at_h, at_v);
        else repeat ($urandom_range(200)) cycle();
        n_wr = 0; n_alive = 0; n_done = 0;
        origin_x_in = LOG_BOARD_SIZE'(ox);
        origin_y_in = LOG_BOARD_SIZE'(oy);
        stamp_in = 1'b1;
        cycle();
        stamp_in = 1'b0;
        check({tag, "_busy"}, {31'd0, busy_out}, 32'd1);
        while (n_done == 0 && g < 3 * FRAME) begin
            cycle();
            g++;
        end
        repeat (4) cycle();
        check({tag, "_done"}, n_done, 1);
        check({tag, "_wr_count"}, n_wr, exp_wr);
        check({tag, "_alive_count"}, n_alive, exp_alive);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, g, ox, oy;
        rst_in = 1'b1; byte_valid_in = 1'b0; byte_in = '0; stamp_in = 1'b0;
        origin_x_in = '0; origin_y_in = '0;
        drive_raster();
        repeat (2) @(posedge clk_in);
        #1;
        repeat (3) cycle();
        rst_in = 1'b0;

        // Glider load and stamp, armed mid-frame at raster (5,7)
        for (int i = 0; i < NB; i++) cur_bytes[i] = 8'h00;
        cur_bytes[0] = 8'h40; cur_bytes[2] = 8'h20; cur_bytes[4] = 8'hE0;
        load_pattern(0, 1'b0, k);
        check("glider_load", k, NB);
        do_stamp("glider", 10, 20, 5, 7, CLEAR ? B * B : 256, 5);

        // Byte and stamp together in READY: the byte wins, load restarts
        byte_valid_in = 1'b1; byte_in = cur_bytes[0]; stamp_in = 1'b1;
        origin_x_in = '0; origin_y_in = '0;
        cycle();
        stamp_in = 1'b0; byte_valid_in = 1'b0;
        check("coincide_noarm", {31'd0, busy_out}, 32'd0);
        load_pattern(1, 1'b0, k);
        check("reload", k, NB);

        // Clipping at the bottom-right corner
        do_stamp("clip", B - 4, B - 2, -1, -1, CLEAR ? B * B : 8, 2);

        // Byte stream held valid across ARMED/STAMP/DONE
        for (int i = 0; i < NB; i++) cur_bytes[i] = 8'($urandom);
        origin_x_in = LOG_BOARD_SIZE'($urandom_range(B - 1));
        origin_y_in = LOG_BOARD_SIZE'($urandom_range(B - 1));
        stamp_in = 1'b1;
        cycle();
        stamp_in = 1'b0;
        n_done = 0;
        load_pattern(0, 1'b1, k);
        check("stall_load", k, NB);
        check("stall_done", n_done, 1);
        ox = $urandom_range(B - 1); oy = $urandom_range(B - 1);
        do_stamp("stall_restamp", ox, oy, -1, -1, wr_in_window(ox, oy), alive_in_window(ox, oy));

        // Reset in the middle of a stamp frame
        ox = $urandom_range(40); oy = $urandom_range(20);
        origin_x_in = LOG_BOARD_SIZE'(ox); origin_y_in = LOG_BOARD_SIZE'(oy);
        stamp_in = 1'b1;
        cycle();
        stamp_in = 1'b0;
        g = 0;
        while (!(m_phase == 2 && v_in == 30) && g < 3 * FRAME) begin
            cycle();
            g++;
        end
        check("rst_reach_stamp", {31'd0, busy_out}, 32'd1);
        rst_in = 1'b1;
        n_done = 0;
        cycle();
        rst_in = 1'b0;
        check("rst_wr_off", {30'd0, wr_en_out, alive_out}, 32'd0);
        repeat (50) cycle();
        check("rst_ready", {31'd0, byte_ready_out}, 32'd1);
        stamp_in = 1'b1;
        cycle();
        stamp_in = 1'b0;
        check("rst_stamp_ignored", {31'd0, busy_out}, 32'd0);
        repeat (FRAME + 10) cycle();
        check("rst_no_done", n_done, 0);
        for (int i = 0; i < NB; i++) cur_bytes[i] = 8'($urandom);
        load_pattern(0, 1'b0, k);
        check("rst_reload", k, NB);
        ox = $urandom_range(B - 1); oy = $urandom_range(B - 1);
        do_stamp("final", ox, oy, -1, -1, wr_in_window(ox, oy), alive_in_window(ox, oy));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
